// File: rtl/sub_bcd_if.sv
// Handshake and data bundle for the subtract-and-convert engine.
// The master drives the request and operands; the slave returns the signed BCD result.
interface sub_bcd_if #(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 6
);
    logic                  start;
    logic [WIDTH-1:0]      num_1;
    logic [WIDTH-1:0]      num_2;
    logic                  busy;
    logic                  done;
    logic                  neg;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output start, num_1, num_2,
        input  busy, done, neg, bcd, ovf
    );

    modport slave (
        input  start, num_1, num_2,
        output busy, done, neg, bcd, ovf
    );
endinterface

// File: rtl/sub_bcd_unit.sv
// Sequential num_1 - num_2 with sign/magnitude output and shift-add-3 BCD conversion.
// Optional clamp of the displayed magnitude is enabled with macro SUB_BCD_CLAMP_EN.
module sub_bcd_unit #(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 6
) (
    input  logic     clk,
    input  logic     rst,
    sub_bcd_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_t            state_r;
    state_t            next_state_s;
    logic [WIDTH-1:0]  num_1_r;
    logic [WIDTH-1:0]  num_2_r;
    logic [WIDTH-1:0]  shift_r;
    logic [WIDTH-1:0]  mag_s;
    logic              neg_s;
    logic [BCD_W-1:0]  scratch_r;
    logic [BCD_W-1:0]  adj_s;
    logic [BCD_W-1:0]  bcd_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              neg_stage_r;
    logic              neg_r;
    logic              busy_r;
    logic              done_r;

    // Add 3 to every digit that would overflow past 9 once doubled by the shift.
    function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

`ifdef SUB_BCD_CLAMP_EN
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    function automatic logic [BCD_W-1:0] clamp_pattern();
        logic [BCD_W-1:0] p;
        p = {BCD_W{1'b0}};
        for (int i = 0; i < DIGITS - 1; i++) begin
            p[4*i +: 4] = 4'd9;
        end
        return p;
    endfunction

    localparam logic [63:0]      CLAMP_LIMIT = pow10(DIGITS - 1) - 64'd1;
    localparam logic [BCD_W-1:0] CLAMP_BCD   = clamp_pattern();

    logic over_stage_r;
    logic ovf_r;
`endif

    // Sign and magnitude: always subtract the smaller operand from the larger.
    always_comb begin
        neg_s = 1'b0;
        mag_s = {WIDTH{1'b0}};
        if (num_1_r >= num_2_r) begin
            neg_s = 1'b0;
            mag_s = num_1_r - num_2_r;
        end else begin
            neg_s = 1'b1;
            mag_s = num_2_r - num_1_r;
        end
    end

    // Digit correction ahead of each conversion shift.
    always_comb begin
        adj_s = add3_adjust(scratch_r);
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    next_state_s = SUB;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SUB:  next_state_s = CONV;
            CONV: begin
                if (cnt_r == CNT_W'(1)) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = CONV;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture, conversion datapath and published result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_1_r      <= {WIDTH{1'b0}};
            num_2_r      <= {WIDTH{1'b0}};
            shift_r      <= {WIDTH{1'b0}};
            scratch_r    <= {BCD_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            neg_stage_r  <= 1'b0;
            neg_r        <= 1'b0;
            bcd_r        <= {BCD_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
`ifdef SUB_BCD_CLAMP_EN
            over_stage_r <= 1'b0;
            ovf_r        <= 1'b0;
`endif
        end else begin
            busy_r <= (next_state_s == SUB) || (next_state_s == CONV);
            done_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        num_1_r <= bus.num_1;
                        num_2_r <= bus.num_2;
                    end
                end
                SUB: begin
                    neg_stage_r  <= neg_s;
                    shift_r      <= mag_s;
                    scratch_r    <= {BCD_W{1'b0}};
                    cnt_r        <= CNT_W'(WIDTH);
`ifdef SUB_BCD_CLAMP_EN
                    over_stage_r <= (64'(mag_s) > CLAMP_LIMIT);
`endif
                end
                CONV: begin
                    scratch_r <= {adj_s[BCD_W-2:0], shift_r[WIDTH-1]};
                    shift_r   <= {shift_r[WIDTH-2:0], 1'b0};
                    cnt_r     <= cnt_r - CNT_W'(1);
                end
                DONE: begin
                    neg_r <= neg_stage_r;
`ifdef SUB_BCD_CLAMP_EN
                    if (over_stage_r) begin
                        bcd_r <= CLAMP_BCD;
                        ovf_r <= 1'b1;
                    end else begin
                        bcd_r <= scratch_r;
                        ovf_r <= 1'b0;
                    end
`else
                    bcd_r <= scratch_r;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.neg  = neg_r;
    assign bus.bcd  = bcd_r;
`ifdef SUB_BCD_CLAMP_EN
    assign bus.ovf  = ovf_r;
`else
    assign bus.ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_sub_bcd_unit.sv
// Bench for sub_bcd_unit: cycle-level reference model plus directed vectors with literal results.
// Literal expectations follow SUB_BCD_CLAMP_EN when it is defined.
module tb_sub_bcd_unit;
    localparam int WIDTH  = 17;
    localparam int DIGITS = 6;
`ifdef SUB_BCD_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic check_en = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    sub_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    sub_bcd_unit #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Decimal digits by plain division, with the display clamp when enabled.
    function automatic logic [23:0] to_bcd(input int m);
        logic [23:0] r;
        int v;
        r = 24'h0;
        v = m;
        if (CLAMP && m > 99999) return 24'h099999;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference model: an accepted start at edge k gives busy after edges k..k+WIDTH,
    // a result and done pulse after edge k+WIDTH+2, and the next acceptance from edge k+WIDTH+3.
    int          cyc = 0;
    int          acc_cyc = -1000;
    int          pend_mag = 0;
    logic        pend_neg = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_neg = 1'b0;
    logic        exp_ovf = 1'b0;
    logic [23:0] exp_bcd = 24'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc      <= 0;
            acc_cyc  <= -1000;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_neg  <= 1'b0;
            exp_ovf  <= 1'b0;
            exp_bcd  <= 24'h0;
        end else begin
            cyc      <= cyc + 1;
            exp_done <= (cyc + 1 == acc_cyc + WIDTH + 2);
            if (cyc + 1 == acc_cyc + WIDTH + 2) begin
                exp_bcd <= to_bcd(pend_mag);
                exp_neg <= pend_neg;
                exp_ovf <= CLAMP && (pend_mag > 99999);
            end
            if (bus.start && (cyc + 1 >= acc_cyc + WIDTH + 3)) begin
                acc_cyc  <= cyc + 1;
                pend_mag <= (int'(bus.num_1) >= int'(bus.num_2)) ? int'(bus.num_1) - int'(bus.num_2)
                                                                  : int'(bus.num_2) - int'(bus.num_1);
                pend_neg <= (bus.num_1 < bus.num_2);
                exp_busy <= 1'b1;
            end else begin
                exp_busy <= (cyc + 1 >= acc_cyc) && (cyc + 1 <= acc_cyc + WIDTH);
            end
        end
    end

    // Directed checks are posted here so that one process owns the counters.
    string       post_name = "";
    logic [63:0] post_act = 64'h0;
    logic [63:0] post_exp = 64'h0;
    int          post_seq = 0;
    int          post_ack = 0;

    task automatic post(input string nm, input logic [63:0] a, input logic [63:0] e);
        post_name = nm;
        post_act  = a;
        post_exp  = e;
        post_seq  = post_seq + 1;
        wait (post_ack == post_seq);
    endtask

    // Single compare process: model vs DUT every cycle, then any posted literal check.
    always begin
        @(negedge clk);
        if (check_en) begin
            n_cmp = n_cmp + 5;
            if (bus.busy !== exp_busy) begin
                n_fail++; $display("FAIL busy @%0t: got %0h want %0h", $time, bus.busy, exp_busy);
            end
            if (bus.done !== exp_done) begin
                n_fail++; $display("FAIL done @%0t: got %0h want %0h", $time, bus.done, exp_done);
            end
            if (bus.neg !== exp_neg) begin
                n_fail++; $display("FAIL neg @%0t: got %0h want %0h", $time, bus.neg, exp_neg);
            end
            if (bus.ovf !== exp_ovf) begin
                n_fail++; $display("FAIL ovf @%0t: got %0h want %0h", $time, bus.ovf, exp_ovf);
            end
            if (bus.bcd !== exp_bcd) begin
                n_fail++; $display("FAIL bcd @%0t: got %06h want %06h", $time, bus.bcd, exp_bcd);
            end
        end
        if (post_ack != post_seq) begin
            n_cmp++;
            if (post_act !== post_exp) begin
                n_fail++;
                $display("FAIL %s: got %0h want %0h", post_name, post_act, post_exp);
            end
            post_ack = post_seq;
        end
    end

    // One operation with literal result, latency and busy-length checks.
    task automatic run_op(input int a, input int b, input logic [23:0] eb,
                          input logic en, input logic eo, input string nm);
        int lat;
        int bcnt;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_1 = 17'(a); bus.num_2 = 17'(b);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.num_1 = 17'($urandom_range(0, 131071));
        bus.num_2 = 17'($urandom_range(0, 131071));
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) bcnt++;
        end
        post({nm, "_latency"}, 64'(lat), 64'd19);
        post({nm, "_busy_cycles"}, 64'(bcnt), 64'd18);
        post({nm, "_bcd"}, 64'(bus.bcd), 64'(eb));
        post({nm, "_neg"}, 64'(bus.neg), 64'(en));
        post({nm, "_ovf"}, 64'(bus.ovf), 64'(eo));
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        post({nm, "_drained"}, 64'(bus.done), 64'd1);
    endtask

    initial begin
        int cnt;
        int last;
        int gap;
        bus.start = 1'b0;
        bus.num_1 = 17'd0;
        bus.num_2 = 17'd0;
        #2 rst = 1'b1;
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        post("reset_bcd", 64'(bus.bcd), 64'd0);
        post("reset_busy", 64'(bus.busy), 64'd0);

        run_op(12345, 345, 24'h012000, 1'b0, 1'b0, "basic");
        run_op(5, 12, 24'h000007, 1'b1, 1'b0, "negative");
        run_op(777, 777, 24'h000000, 1'b0, 1'b0, "equal");
        run_op(0, 0, 24'h000000, 1'b0, 1'b0, "zero");
        run_op(99999, 0, 24'h099999, 1'b0, 1'b0, "edge_99999");
        run_op(100000, 0, CLAMP ? 24'h099999 : 24'h100000, 1'b0, CLAMP, "edge_100000");
        run_op(0, 131071, CLAMP ? 24'h099999 : 24'h131071, 1'b1, CLAMP, "neg_max");
        run_op(131071, 0, CLAMP ? 24'h099999 : 24'h131071, 1'b0, CLAMP, "max");

        // start held high with operands changing every cycle
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.num_1 = 17'($urandom_range(0, 131071));
        bus.num_2 = 17'($urandom_range(0, 131071));
        cnt = 0; last = -1; gap = 0;
        for (int i = 1; i <= 65; i++) begin
            @(posedge clk); #1;
            bus.num_1 = 17'($urandom_range(0, 131071));
            bus.num_2 = 17'($urandom_range(0, 131071));
            if (bus.done) begin
                if (last >= 0) gap = i - last;
                last = i;
                cnt++;
            end
        end
        bus.start = 1'b0;
        post("held_done_count", 64'(cnt), 64'd3);
        post("held_done_gap", 64'(gap), 64'd20);
        drain("held");

        // start pulses while busy and in DONE are ignored
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_1 = 17'd50000; bus.num_2 = 17'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0;
        for (int j = 1; j <= 45; j++) begin
            @(posedge clk); #1;
            bus.start = (j == 4) || (j == 9) || (j == 16) || (j == 18);
            if (bus.done) cnt++;
        end
        bus.start = 1'b0;
        post("busy_start_dones", 64'(cnt), 64'd1);
        post("busy_start_bcd", 64'(bus.bcd), 64'h049999);

        // reset five cycles into an operation
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_1 = 17'd131071; bus.num_2 = 17'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        post("rst_mid_bcd", 64'(bus.bcd), 64'd0);
        post("rst_mid_busy", 64'(bus.busy), 64'd0);
        post("rst_mid_neg", 64'(bus.neg), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        for (int j = 0; j < 25; j++) begin
            @(posedge clk); #1;
            if (bus.done) cnt++;
        end
        post("rst_no_done", 64'(cnt), 64'd0);
        run_op(100, 1, 24'h000099, 1'b0, 1'b0, "after_rst");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sub_bcd_unit.md
Name: sub_bcd_unit

Overview:
- Sequential subtract-and-convert engine for the calculator datapath; the inverse operation of the existing combinational adder.
- Computes num_1 - num_2 on unsigned 17-bit operands and produces a sign flag plus a BCD magnitude for the 7-segment display path.
- Binary-to-BCD conversion is iterative (shift-add-3), one bit per clock.
- Uses a start/busy/done handshake and holds the result until the next accepted start.

Parameters:
- WIDTH, 17, operand width in bits.
- DIGITS, 6, number of BCD digits output; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- num_1  input  WIDTH  minuend, captured on accepted start.
- num_2  input  WIDTH  subtrahend, captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle pulse when the result is valid.
- neg  output  1  result sign; 1 when num_1 < num_2.
- bcd  output  4*DIGITS  BCD magnitude; digit 0 is in bits [3:0].
- ovf  output  1  clamp indicator (see Optional Feature).

Behaviour:
- Reset (async, any state): state = IDLE; busy, done, neg, ovf = 0; bcd = 0; internal shift and scratch registers = 0.
- States: IDLE, SUB, CONV, DONE.
- IDLE:
  - start=1 at a clock edge captures num_1/num_2 into registers and moves to SUB.
  - start=0 stays in IDLE.
  - Outputs keep their last result.
- SUB (1 cycle):
  - If num_1 >= num_2: neg=0, mag = num_1 - num_2. Otherwise neg=1, mag = num_2 - num_1.
  - Width rule: mag is WIDTH bits and never wraps, because the subtraction is always larger minus smaller.
  - Equal operands give mag=0 and neg=0; negative zero is never produced.
  - Load the shift register with mag, clear the BCD scratch, set the bit counter to WIDTH, go to CONV.
- CONV (exactly WIDTH cycles):
  - Each cycle: add 3 to every scratch digit that is >= 5, then shift {scratch, shift} left by 1 and decrement the counter.
  - When the counter reaches 0, go to DONE.
- DONE (1 cycle):
  - bcd <= scratch, done = 1, busy = 0; return to IDLE.
- Busy window: busy = 1 exactly while in SUB or CONV.
- Latency: start accepted at edge k -> done high during cycle k+WIDTH+2, which is 19 cycles for the defaults. bcd and neg update at the same edge that raises done.
- neg timing: neg is staged internally and published together with bcd in DONE, so outputs never show a mixed old/new result.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE, i.e. back-to-back every WIDTH+3 cycles.
- Operand changes after acceptance: no effect on the operation in flight.
- Reset mid-operation: aborts immediately; all outputs return to reset values; no done pulse.

Optional Feature:
- Macro: SUB_BCD_CLAMP_EN.
- Defined:
  - In DONE, if mag > 10^(DIGITS-1) - 1 (99999 for the defaults), bcd is forced to all-nines in the low DIGITS-1 digits with the top digit 0, and ovf = 1.
  - ovf updates with done and holds until the next DONE or reset.
  - neg is unaffected by the clamp.
- Undefined:
  - No clamp; the full DIGITS-digit result is output.
  - ovf is tied to 0.

Test Plan:
- Basic subtract: num_1=12345, num_2=345, start pulse -> done exactly 19 cycles later; bcd=0x012000, neg=0, ovf=0; busy high for 18 cycles.
- Negative result: num_1=5, num_2=12 -> bcd=0x000007, neg=1.
- Equal operands, then zero result:
  - num_1=num_2=777 -> bcd=0x000000, neg=0.
  - num_1=0, num_2=0 -> same result.
- Maximum magnitude: num_1=131071, num_2=0 -> bcd=0x131071, ovf=0 without the macro; bcd=0x099999, ovf=1, neg=0 with SUB_BCD_CLAMP_EN.
- Handshake:
  - Hold start=1 with operands changing every cycle -> only operands present at accepted edges are used.
  - done pulses are 1 cycle wide, spaced 20 cycles apart.
  - start pulses during busy produce no extra done.
- Reset mid-CONV: assert rst 5 cycles into an operation -> busy, done, bcd, neg, ovf = 0 immediately, with no done.
  - After release, a new start (100 - 1) -> bcd=0x000099, neg=0.
